// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one serial multiplier between two
// requesters: latch operand, strobe start, shift LSB-first, capture product.
module mult_arbiter #(
    parameter int OP_W         = 32,
    parameter int SHIFT_CYCLES = 33,
    parameter int RES_W        = 33
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [OP_W-1:0]  op0,
    input  logic [OP_W-1:0]  op1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [1:0]       done,
    output logic [RES_W-1:0] result,
    output logic             mult_start,
    output logic             mult_bit,
    input  logic [RES_W-1:0] mult_result
);

    localparam int CW = $clog2(SHIFT_CYCLES);

    typedef enum logic [1:0] {IDLE, START, SHIFT, CAPTURE} state_t;

    state_t           state, state_d;
    logic [OP_W-1:0]  sreg, sreg_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             last, last_d;
    logic             win;
    logic [1:0]       grant_d, done_d;
    logic             busy_d, start_d, bit_d;
    logic [RES_W-1:0] result_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            last       <= 1'b1;
            grant      <= '0;
            busy       <= 1'b0;
            done       <= '0;
            result     <= '0;
            mult_start <= 1'b0;
            mult_bit   <= 1'b0;
        end else begin
            state      <= state_d;
            sreg       <= sreg_d;
            cnt        <= cnt_d;
            last       <= last_d;
            grant      <= grant_d;
            busy       <= busy_d;
            done       <= done_d;
            result     <= result_d;
            mult_start <= start_d;
            mult_bit   <= bit_d;
        end
    end

    always_comb begin
        state_d  = state;
        sreg_d   = sreg;
        cnt_d    = cnt;
        last_d   = last;
        grant_d  = grant;
        busy_d   = busy;
        done_d   = '0;
        result_d = result;
        start_d  = 1'b0;
        bit_d    = 1'b0;
        win      = 1'b0;
        unique case (state)
            IDLE: begin
                // Requests seen during the done pulse are still the old owner's.
                if (done == 2'b00 && req != 2'b00) begin
                    win     = (req == 2'b11) ? ~last : req[1];
                    grant_d = win ? 2'b10 : 2'b01;
                    sreg_d  = win ? op1 : op0;
                    last_d  = win;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                bit_d   = sreg[0];
                sreg_d  = sreg >> 1;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt == CW'(SHIFT_CYCLES - 1)) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d  = cnt + 1'b1;
                    bit_d  = sreg[0];
                    sreg_d = sreg >> 1;
                end
            end
            CAPTURE: begin
                result_d = mult_result;
                done_d   = grant;
                grant_d  = '0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter.
// Model, monitors, reset and wait checks.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [31:0] op0 = '0;
  logic [31:0] op1 = '0;
  logic [1:0]  grant, done;
  logic        busy, mult_start, mult_bit;
  logic [32:0] result;
  logic [32:0] mult_result = '0;

  mult_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .op0(op0), .op1(op1),
    .grant(grant), .busy(busy),
    .done(done), .result(result),
    .mult_start(mult_start),
    .mult_bit(mult_bit),
    .mult_result(mult_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          s;
    logic [1:0]  g;
    logic [31:0] op;
  } txn_t;

  txn_t        q[$];
  int          cyc = 0;
  logic [32:0] mr_hist [int];
  int          avail = 0;
  int          last = 1;
  bit          started = 1'b0;
  logic [32:0] exp_res = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) begin
    mr_hist[cyc] = mult_result;
    if (rst) begin
      q.delete();
      last    = 1;
      avail   = cyc + 1;
      started = 1'b1;
      exp_res = '0;
    end else if (started && cyc >= avail &&
                 req != 2'b00) begin
      int w;
      w = (req == 2'b11) ? 1 - last
                         : int'(req[1]);
      last = w;
      q.push_back('{cyc + 1,
                    (w == 1) ? 2'b10 : 2'b01,
                    (w == 1) ? op1 : op0});
      avail = cyc + 37;
    end
    cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    if (started) begin
      logic [1:0] eg, ed;
      logic       eb, es, ebit;
      int         k;
      eg = 2'b00; ed = 2'b00;
      eb = 1'b0; es = 1'b0; ebit = 1'b0;
      if (q.size() > 0 && cyc >= q[0].s) begin
        k = cyc - q[0].s;
        if (k <= 34) begin
          eg = q[0].g;
          eb = 1'b1;
          es = (k == 0);
          if (k >= 1 && k <= 32)
            ebit = q[0].op[k-1];
        end else begin
          ed      = q[0].g;
          exp_res = mr_hist[q[0].s + 34];
          void'(q.pop_front());
        end
      end
      n_cmp++;
      if ({grant, busy, done, mult_start,
           mult_bit, result} !==
          {eg, eb, ed, es, ebit, exp_res}) begin
        n_bad++;
        $display("FAIL cyc%0d got g=%b b=%b d=%b st=%b bit=%b r=%h want g=%b b=%b d=%b st=%b bit=%b r=%h",
                 cyc, grant, busy, done,
                 mult_start, mult_bit, result,
                 eg, eb, ed, es, ebit, exp_res);
      end
    end
  end

  always @(posedge clk) begin
    logic r;
    r = rst;
    #1;
    if (r) begin
      n_cmp++;
      if ({grant, busy, done, mult_start,
           mult_bit, result} !== '0) begin
        n_bad++;
        $display("FAIL cyc%0d reset state: g=%b b=%b d=%b st=%b bit=%b r=%h",
                 cyc, grant, busy, done,
                 mult_start, mult_bit, result);
      end
    end
  end

  bit [1:0] drop_next = 2'b00;

  task automatic step(input int mode);
    @(negedge clk);
    rst = 1'b0;
    mult_result = {1'($urandom_range(1)),
                   32'($urandom)};
    for (int i = 0; i < 2; i++) begin
      if (drop_next[i]) begin
        req[i] = 1'b0;
        drop_next[i] = 1'b0;
      end else if (req[i] && done[i]) begin
        if (mode != 2) drop_next[i] = 1'b1;
      end else if (!req[i] && mode == 1 &&
                   $urandom_range(7) == 0) begin
        req[i] = 1'b1;
      end
    end
    if (mode == 1) begin
      op0 = $urandom;
      op1 = $urandom;
      if ($urandom_range(399) == 0)
        rst = 1'b1;
    end
  endtask

  task automatic wait_done(
    input logic [1:0] m,
    input int         lim
  );
    int n;
    n = 0;
    while (done !== m && n < lim) begin
      step(0);
      n++;
    end
    n_cmp++;
    if (done !== m) begin
      n_bad++;
      $display("FAIL cyc%0d wait for done=%b expired",
               cyc, m);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    op0 = 32'h0000_0305;
    req = 2'b01;
    wait_done(2'b01, 45);
    repeat (8) step(0);

    rst = 1'b1;
    step(0);
    rst = 1'b1;
    req = 2'b11;
    repeat (4 * 37 + 6) step(2);
    req = 2'b00;
    drop_next = 2'b00;
    repeat (40) step(0);

    op0 = 32'hA5C3_0F81;
    req = 2'b01;
    repeat (5) step(0);
    op0 = 32'h1234_5678;
    wait_done(2'b01, 45);
    repeat (8) step(0);

    req = 2'b10;
    op1 = 32'hDEAD_BEEF;
    repeat (10) step(0);
    rst = 1'b1;
    step(0);
    wait_done(2'b10, 45);
    repeat (8) step(0);

    repeat (3000) step(1);
    repeat (80) step(0);
    req = 2'b00;
    repeat (3) step(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
